// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, immediate formats and the
// opcode-to-format mapping used by the decode stage.
package decode_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_R,
        FMT_ILL
    } imm_fmt_e;

    // Unknown opcodes map to FMT_ILL so the caller needs no separate legality table.
    function automatic imm_fmt_e opcode_fmt(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OP_IMM, JALR, LOAD: fmt = FMT_I;
            STORE:              fmt = FMT_S;
            BRANCH:             fmt = FMT_B;
            AUIPC, LUI:         fmt = FMT_U;
            JAL:                fmt = FMT_J;
            OP:                 fmt = FMT_R;
            default:            fmt = FMT_ILL;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator and register-usage decode for one
// 32-bit instruction word. The immediate is formed as a signed 32-bit value
// and then sign-extended to XLEN, so XLEN = 64 needs no extra cases.
module decode_imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit ZERO_EXT_SHAMT = 1'b1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic            is_load,
    output logic            illegal
);

    imm_fmt_e          fmt;
    logic signed [31:0] imm32;
    logic              shamt_zext;

    // Widen a 32-bit signed immediate to the datapath width.
    function automatic logic [XLEN-1:0] sext_to_xlen(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    assign fmt        = (instr[1:0] != 2'b11) ? FMT_ILL : opcode_fmt(instr[6:0]);
    // Shift-immediate forms (func3 001/101) carry a shift amount, not a signed constant.
    assign shamt_zext = ZERO_EXT_SHAMT && (instr[6:0] == OP_IMM) && (instr[13:12] == 2'b01);

    // Per-format immediate assembly and operand usage; illegal encodings decode to all zeros.
    always_comb begin
        imm32    = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        is_load  = 1'b0;
        illegal  = 1'b0;
        case (fmt)
            FMT_I: begin
                imm32    = shamt_zext ? {20'b0, instr[31:20]} : {{20{instr[31]}}, instr[31:20]};
                uses_rs1 = 1'b1;
                is_load  = (instr[6:0] == LOAD);
            end
            FMT_S: begin
                imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            FMT_B: begin
                imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            FMT_U: begin
                imm32 = {instr[31:12], 12'b0};
            end
            FMT_J: begin
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            FMT_R: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = sext_to_xlen(imm32);

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage: valid/ready intake from fetch, one register stage
// toward execute, load-use bubble insertion, flush and a saturating bubble
// counter.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit ZERO_EXT_SHAMT = 1'b1,
    parameter int BUBBLE_CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_instr,
    input  logic [XLEN-1:0]         in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [6:0]              out_opcode,
    output logic [2:0]              out_func3,
    output logic [6:0]              out_func7,
    output logic [4:0]              out_rd,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [XLEN-1:0]         out_imm,
    output logic [XLEN-1:0]         out_pc,
    output logic                    out_uses_rs1,
    output logic                    out_uses_rs2,
    output logic                    out_is_load,
    output logic                    out_illegal,
    output logic [BUBBLE_CNT_W-1:0] bubble_count
);

    logic [XLEN-1:0] dec_imm;
    logic            dec_uses_rs1;
    logic            dec_uses_rs2;
    logic            dec_is_load;
    logic            dec_illegal;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic            hazard;
    logic            accept;
    logic            bubble;

    logic                    vld_p1;
    logic [6:0]              opcode_p1;
    logic [2:0]              func3_p1;
    logic [6:0]              func7_p1;
    logic [4:0]              rd_p1;
    logic [4:0]              rs1_p1;
    logic [4:0]              rs2_p1;
    logic [XLEN-1:0]         imm_p1;
    logic [XLEN-1:0]         pc_p1;
    logic                    uses_rs1_p1;
    logic                    uses_rs2_p1;
    logic                    is_load_p1;
    logic                    illegal_p1;
    logic [BUBBLE_CNT_W-1:0] bubble_cnt_p1;

    // Counter stops at all ones instead of wrapping.
    function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    decode_imm_gen #(
        .XLEN           (XLEN),
        .ZERO_EXT_SHAMT (ZERO_EXT_SHAMT)
    ) u_imm_gen (
        .instr    (in_instr),
        .imm      (dec_imm),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .is_load  (dec_is_load),
        .illegal  (dec_illegal)
    );

    assign dec_rs1 = in_instr[19:15];
    assign dec_rs2 = in_instr[24:20];

    // A held load whose result the incoming instruction needs; x0 is never a real dependency.
    assign hazard = vld_p1 && is_load_p1 && (rd_p1 != 5'd0) &&
                    ((dec_uses_rs1 && (dec_rs1 == rd_p1)) ||
                     (dec_uses_rs2 && (dec_rs2 == rd_p1)));

    assign in_ready = (!vld_p1 || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign bubble   = hazard && in_valid && out_ready && !flush;

    // ---- stage p0 -> p1: decoded bundle register toward execute ----
    // Flush wins over everything; otherwise load on accept, drop valid on a bare consume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            opcode_p1   <= '0;
            func3_p1    <= '0;
            func7_p1    <= '0;
            rd_p1       <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            imm_p1      <= '0;
            pc_p1       <= '0;
            uses_rs1_p1 <= 1'b0;
            uses_rs2_p1 <= 1'b0;
            is_load_p1  <= 1'b0;
            illegal_p1  <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1      <= 1'b1;
            opcode_p1   <= in_instr[6:0];
            func3_p1    <= in_instr[14:12];
            func7_p1    <= in_instr[31:25];
            rd_p1       <= in_instr[11:7];
            rs1_p1      <= dec_rs1;
            rs2_p1      <= dec_rs2;
            imm_p1      <= dec_imm;
            pc_p1       <= in_pc;
            uses_rs1_p1 <= dec_uses_rs1;
            uses_rs2_p1 <= dec_uses_rs2;
            is_load_p1  <= dec_is_load;
            illegal_p1  <= dec_illegal;
        end else if (vld_p1 && out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // Count each cycle the load-use interlock turns a consume into a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt_p1 <= '0;
        end else if (bubble) begin
            bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
        end
    end

    assign out_valid    = vld_p1;
    assign out_opcode   = opcode_p1;
    assign out_func3    = func3_p1;
    assign out_func7    = func7_p1;
    assign out_rd       = rd_p1;
    assign out_rs1      = rs1_p1;
    assign out_rs2      = rs2_p1;
    assign out_imm      = imm_p1;
    assign out_pc       = pc_p1;
    assign out_uses_rs1 = uses_rs1_p1;
    assign out_uses_rs2 = uses_rs2_p1;
    assign out_is_load  = is_load_p1;
    assign out_illegal  = illegal_p1;
    assign bubble_count = bubble_cnt_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage. Two instances share one stimulus:
// a 32-bit datapath with a 2-bit bubble counter and a 64-bit datapath with
// the default counter, both compared against a behavioural model.
module tb_decode_stage;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic [63:0] pc;
        logic        u1;
        logic        u2;
        logic        ld;
        logic        ill;
    } bun_t;

    typedef struct packed {
        logic [63:0] imm;
        logic        u1;
        logic        u2;
        logic        ld;
        logic        ill;
    } dec_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_rdy, a_vld, a_u1, a_u2, a_ld, a_ill;
    logic [6:0]  a_op, a_f7;
    logic [2:0]  a_f3;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [31:0] a_imm, a_pc;
    logic [1:0]  a_bcnt;

    logic        b_rdy, b_vld, b_u1, b_u2, b_ld, b_ill;
    logic [6:0]  b_op, b_f7;
    logic [2:0]  b_f3;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [63:0] b_imm, b_pc;
    logic [15:0] b_bcnt;

    bun_t a_bun, b_bun;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state: what execute should currently see.
    logic        m_vld;
    logic        m_zero;
    logic [31:0] m_instr;
    logic [63:0] m_pc;
    int          m_bcnt;
    logic        m_acc;

    decode_stage #(.XLEN(32), .ZERO_EXT_SHAMT(1'b1), .BUBBLE_CNT_W(2)) u_dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_vld), .out_ready(out_ready),
        .out_opcode(a_op), .out_func3(a_f3), .out_func7(a_f7), .out_rd(a_rd),
        .out_rs1(a_rs1), .out_rs2(a_rs2), .out_imm(a_imm), .out_pc(a_pc),
        .out_uses_rs1(a_u1), .out_uses_rs2(a_u2), .out_is_load(a_ld),
        .out_illegal(a_ill), .bubble_count(a_bcnt)
    );

    decode_stage #(.XLEN(64), .ZERO_EXT_SHAMT(1'b1), .BUBBLE_CNT_W(16)) u_dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_rdy),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_vld), .out_ready(out_ready),
        .out_opcode(b_op), .out_func3(b_f3), .out_func7(b_f7), .out_rd(b_rd),
        .out_rs1(b_rs1), .out_rs2(b_rs2), .out_imm(b_imm), .out_pc(b_pc),
        .out_uses_rs1(b_u1), .out_uses_rs2(b_u2), .out_is_load(b_ld),
        .out_illegal(b_ill), .bubble_count(b_bcnt)
    );

    assign a_bun = {a_op, a_f3, a_f7, a_rd, a_rs1, a_rs2, 32'b0, a_imm, 32'b0, a_pc,
                    a_u1, a_u2, a_ld, a_ill};
    assign b_bun = {b_op, b_f3, b_f7, b_rd, b_rs1, b_rs2, b_imm, b_pc,
                    b_u1, b_u2, b_ld, b_ill};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Interpret a value of 'bits' width as two's complement.
    function automatic longint sx(input longint v, input int bits);
        longint one;
        one = 1;
        if (v >= (one << (bits - 1))) return v - (one << bits);
        return v;
    endfunction

    // Reference decode built from the field layout with integer arithmetic.
    function automatic dec_t mdec(input logic [31:0] i, input int xlen);
        dec_t   d;
        longint u;
        longint v;
        u = longint'({32'b0, i});
        v = 0;
        d = '0;
        case (i[6:0])
            7'h13, 7'h67, 7'h03: begin
                v = u >> 20;
                if (!(i[6:0] == 7'h13 && (i[14:12] == 3'd1 || i[14:12] == 3'd5))) v = sx(v, 12);
                d.u1 = 1'b1;
                d.ld = (i[6:0] == 7'h03);
            end
            7'h23: begin
                v = sx(((u >> 25) << 5) + ((u >> 7) & 31), 12);
                d.u1 = 1'b1;
                d.u2 = 1'b1;
            end
            7'h63: begin
                v = sx(((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048 +
                       ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2, 13);
                d.u1 = 1'b1;
                d.u2 = 1'b1;
            end
            7'h17, 7'h37: v = sx(u & 64'hFFFF_F000, 32);
            7'h6F: v = sx(((u >> 31) & 1) * 1048576 + ((u >> 12) & 255) * 4096 +
                          ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2, 21);
            7'h33: begin
                d.u1 = 1'b1;
                d.u2 = 1'b1;
            end
            default: d.ill = 1'b1;
        endcase
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        d.imm = v;
        return d;
    endfunction

    function automatic bun_t exp_bun(input int xlen);
        bun_t b;
        dec_t d;
        b = '0;
        if (m_zero) return b;
        d = mdec(m_instr, xlen);
        b.opcode = m_instr[6:0];
        b.f3     = m_instr[14:12];
        b.f7     = m_instr[31:25];
        b.rd     = m_instr[11:7];
        b.rs1    = m_instr[19:15];
        b.rs2    = m_instr[24:20];
        b.imm    = d.imm;
        b.pc     = (xlen == 32) ? {32'b0, m_pc[31:0]} : m_pc;
        b.u1     = d.u1;
        b.u2     = d.u2;
        b.ld     = d.ld;
        b.ill    = d.ill;
        return b;
    endfunction

    task automatic check_outs();
        chk("out_valid32", a_vld, m_vld);
        chk("out_valid64", b_vld, m_vld);
        chk("bubble_count32", a_bcnt, (m_bcnt > 3) ? 3 : m_bcnt);
        chk("bubble_count64", b_bcnt, m_bcnt % 65536);
        if (m_vld || m_zero) begin
            chk("bundle32", a_bun, exp_bun(32));
            chk("bundle64", b_bun, exp_bun(64));
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic v, input logic rdy, input logic fl);
        in_instr  = instr;
        in_pc     = {$urandom, $urandom};
        in_valid  = v;
        out_ready = rdy;
        flush     = fl;
    endtask

    // One clock: check in_ready ahead of the edge, advance the model, check outputs after it.
    task automatic cyc();
        dec_t di, dm;
        logic hz, rdy;
        #1;
        di  = mdec(in_instr, 64);
        dm  = mdec(m_instr, 64);
        hz  = m_vld && dm.ld && (m_instr[11:7] != 5'd0) &&
              ((di.u1 && in_instr[19:15] == m_instr[11:7]) ||
               (di.u2 && in_instr[24:20] == m_instr[11:7]));
        rdy = (!m_vld || out_ready) && !hz && !flush;
        chk("in_ready32", a_rdy, rdy);
        chk("in_ready64", b_rdy, rdy);
        @(posedge clk);
        m_acc = 1'b0;
        if (hz && in_valid && out_ready && !flush) m_bcnt++;
        if (flush) begin
            m_vld = 1'b0;
        end else if (in_valid && rdy) begin
            m_vld   = 1'b1;
            m_zero  = 1'b0;
            m_instr = in_instr;
            m_pc    = in_pc;
            m_acc   = 1'b1;
        end else if (m_vld && out_ready) begin
            m_vld = 1'b0;
        end
        #1;
        check_outs();
    endtask

    task automatic model_reset();
        m_vld   = 1'b0;
        m_zero  = 1'b1;
        m_instr = '0;
        m_pc    = '0;
        m_bcnt  = 0;
        m_acc   = 1'b0;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] i;
        int k;
        i = $urandom;
        k = $urandom_range(0, 12);
        case (k)
            0, 1, 2: i[6:0] = 7'h03;
            3:       i[6:0] = 7'h13;
            4:       i[6:0] = 7'h67;
            5:       i[6:0] = 7'h23;
            6:       i[6:0] = 7'h63;
            7:       i[6:0] = 7'h17;
            8:       i[6:0] = 7'h37;
            9:       i[6:0] = 7'h6F;
            10, 11:  i[6:0] = 7'h33;
            default: i[6:0] = i[6:0];
        endcase
        i[11:7]  = 5'($urandom_range(0, 7));
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        return i;
    endfunction

    localparam logic [31:0] ADDI_M1  = 32'hFFF0_0093;
    localparam logic [31:0] SLLI_31  = 32'h01F0_9113;
    localparam logic [31:0] LUI_8    = 32'h8000_01B7;
    localparam logic [31:0] BEQ_M4   = 32'hFE00_0EE3;
    localparam logic [31:0] LW_X5    = 32'h0000_A283;
    localparam logic [31:0] ADD_X5   = 32'h0072_8333;
    localparam logic [31:0] LW_X0    = 32'h0000_A003;
    localparam logic [31:0] ADD_X0   = 32'h0070_0333;
    localparam logic [31:0] ADDI_X10 = 32'h00A0_0513;
    localparam logic [31:0] ADDI_X11 = 32'h00B0_0593;
    localparam logic [31:0] ADDI_X12 = 32'h00C0_0613;
    localparam logic [31:0] ILL_RS5  = 32'h0002_807F;

    initial begin
        reset = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        in_pc = '0;
        model_reset();

        // Reset state
        #2;
        check_outs();
        chk("rst_in_ready32", a_rdy, 1'b1);
        chk("rst_in_ready64", b_rdy, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Immediate formats
        drive(ADDI_M1, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("addi_imm32", a_imm, 32'hFFFF_FFFF);
        chk("addi_imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rd", a_rd, 5'd1);
        chk("addi_uses_rs2", a_u2, 1'b0);
        drive(SLLI_31, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("slli_imm32", a_imm, 32'h0000_001F);
        drive(LUI_8, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("lui_imm64", b_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui_imm32", a_imm, 32'h8000_0000);
        drive(BEQ_M4, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("beq_imm32", a_imm, 32'hFFFF_FFFC);

        // Load-use: valid goes 1, 0, 1 with exactly one bubble
        drive(LW_X5, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("lu_valid_load", a_vld, 1'b1);
        drive(ADD_X5, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("lu_valid_bubble", a_vld, 1'b0);
        chk("lu_bubble_count", a_bcnt, 2'd1);
        cyc();
        chk("lu_valid_add", a_vld, 1'b1);
        chk("lu_add_rd", a_rd, 5'd6);

        // Load to x0 never stalls
        drive(LW_X0, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(ADD_X0, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("x0_valid", a_vld, 1'b1);
        chk("x0_rd", a_rd, 5'd6);
        chk("x0_bubble_count", b_bcnt, 16'd1);

        // Back-pressure: bundle held, intake blocked, next accepted when ready rises
        drive(ADDI_X10, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(ADDI_X11, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc();
        chk("bp_held_rd", a_rd, 5'd10);
        chk("bp_in_ready", a_rdy, 1'b0);
        out_ready = 1'b1;
        cyc();
        chk("bp_next_rd", a_rd, 5'd11);

        // Flush with a held bundle and a pending instruction
        drive(ADDI_X12, 1'b1, 1'b0, 1'b1);
        cyc();
        chk("flush_valid", a_vld, 1'b0);
        flush     = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("flush_after_rd", a_rd, 5'd12);
        chk("flush_after_valid", b_vld, 1'b1);

        // Illegal encodings flow through and never stall behind a load
        drive(LW_X5, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(ILL_RS5, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("ill7f_valid", a_vld, 1'b1);
        chk("ill7f_flag", a_ill, 1'b1);
        chk("ill7f_imm", b_imm, 64'h0);
        drive(32'h0000_0000, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("ill00_flag", b_ill, 1'b1);
        chk("ill00_imm", a_imm, 32'h0);

        // Asynchronous reset between edges
        drive(LW_X5, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(ADD_X5, 1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outs();
        chk("areset_valid", a_vld, 1'b0);
        chk("areset_bcnt", b_bcnt, 16'd0);
        #1;
        reset = 1'b0;
        cyc();

        // Saturation of the 2-bit counter after five load-use pairs
        repeat (5) begin
            drive(LW_X5, 1'b1, 1'b1, 1'b0);
            cyc();
            drive(ADD_X5, 1'b1, 1'b1, 1'b0);
            cyc();
            cyc();
        end
        chk("sat_bcnt32", a_bcnt, 2'd3);
        chk("sat_bcnt64", b_bcnt, 16'd5);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            if (!in_valid || m_acc || $urandom_range(0, 3) == 0) begin
                in_instr = rnd_instr();
                in_pc    = {$urandom, $urandom};
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined, parametrised successor to the single-cycle decoder.
- Takes a fetched instruction and its PC through a valid/ready handshake, cracks the fields and generates an XLEN-wide immediate.
- Registers the decoded bundle for the execute stage.
- Adds what the single-cycle decoder lacks: back-pressure, flush, load-use bubble insertion, an illegal-instruction flag and a bubble counter.

Parameters:
- XLEN, 32, datapath/PC/immediate width; legal values 32 or 64.
- ZERO_EXT_SHAMT, 1, 1 = OP-IMM func3 001/101 immediates are zero-extended; 0 = sign-extended like other I-type.
- BUBBLE_CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-high reset.
- flush, input, 1, discard the held instruction and block intake this cycle.
- in_valid, input, 1, fetch presents an instruction.
- in_ready, output, 1, decode accepts this cycle.
- in_instr, input, 32, instruction word.
- in_pc, input, XLEN, PC of in_instr.
- out_valid, output, 1, decoded bundle valid.
- out_ready, input, 1, execute consumes the bundle.
- out_opcode, output, 7, instr[6:0].
- out_func3, output, 3, instr[14:12].
- out_func7, output, 7, instr[31:25].
- out_rd, output, 5, instr[11:7].
- out_rs1, output, 5, instr[19:15].
- out_rs2, output, 5, instr[24:20].
- out_imm, output, XLEN, generated immediate.
- out_pc, output, XLEN, registered PC.
- out_uses_rs1, output, 1, instruction reads rs1.
- out_uses_rs2, output, 1, instruction reads rs2.
- out_is_load, output, 1, opcode 0000011.
- out_illegal, output, 1, unsupported encoding.
- bubble_count, output, BUBBLE_CNT_W, bubbles inserted since reset.

Behaviour:
- Reset: every output register is 0, including out_valid and bubble_count. in_ready is combinational and therefore high after reset unless flush is asserted.
- Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N.
- hazard = out_valid & out_is_load & (out_rd != 0) & ((dec_uses_rs1 & dec_rs1 == out_rd) | (dec_uses_rs2 & dec_rs2 == out_rd)), where dec_* are computed from in_instr.
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Accept (in_valid & in_ready): output register loads the decoded bundle and out_valid becomes 1.
- Consume without accept (out_valid & out_ready & !accept): out_valid becomes 0. When hazard was the blocker, this is the inserted bubble.
- Neither accept nor consume: hold all out_* stable. Once out_valid is high, the bundle must not change until out_ready.
- Load-use: exactly one bubble. The load leaves, out_valid goes low for one cycle, then the dependent instruction is accepted the next cycle. A load with rd = 0 never stalls.
- Flush: at the next edge out_valid = 0 regardless of out_ready; no intake that cycle. Flush overrides accept and hazard.
- Bubble counter: increments when hazard & in_valid & out_ready & !flush. Saturates at all ones and never wraps. Only reset clears it.
- Immediate formats, sign bit instr[31] replicated to XLEN:
  - I (0010011, 1100111, 0000011): instr[31:20]. For OP-IMM func3 001/101 with ZERO_EXT_SHAMT = 1, zero-extended.
  - S (0100011): {instr[31:25], instr[11:7]}.
  - B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U (0010111, 0110111): {instr[31:12], 12'b0}, sign-extended above bit 31 when XLEN = 64.
  - J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R (0110011): 0.
- Illegal: instr[1:0] != 11 or opcode outside the set above. Then out_illegal = 1, imm = 0 and uses_rs1/uses_rs2/is_load = 0, so an illegal instruction never causes a stall. It still flows with out_valid = 1 so execute can trap.
- Register usage:
  - uses_rs1 = 1 for all legal opcodes except LUI, AUIPC, JAL.
  - uses_rs2 = 1 for R, S, B only.
- Simultaneous flush and out_ready: the bubble is not counted and out_valid goes to 0.
- Reset mid-handshake: out_valid drops immediately (asynchronous). Upstream must re-present the instruction.

Decomposition:
- Shared package decode_pkg:
  - Opcode constants: OP_IMM, JALR, LOAD, STORE, BRANCH, AUIPC, LUI, JAL, OP.
  - Immediate-format enum: FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R, FMT_ILL.
- One combinational sub-module, decode_imm_gen, parametrised by XLEN and ZERO_EXT_SHAMT.
  - Input: instr. Outputs: imm, uses_rs1, uses_rs2, is_load, illegal.
  - The handshake, hazard and counter logic stay in decode_stage.

Test Plan:
- Immediates:
  - XLEN = 32, feed addi x1,x0,-1 (0xFFF00093) → out_imm 0xFFFFFFFF, out_rd 1, out_uses_rs2 0.
  - Feed slli x2,x1,31 → out_imm 0x0000001F with ZERO_EXT_SHAMT = 1.
  - XLEN = 64, lui x3,0x80000 → out_imm 0xFFFFFFFF80000000.
  - beq with offset -4 (0xFE000EE3) → out_imm 0xFFFFFFFC.
- Load-use:
  - Stimulus: lw x5,0(x1) followed by add x6,x5,x7, out_ready held high.
  - Required: out_valid sequence 1,0,1 with the add appearing on the third cycle; in_ready low for one cycle; bubble_count 1.
  - Repeat with lw x0 → no bubble; bubble_count unchanged.
- Back-pressure:
  - Stimulus: out_ready = 0 for 3 cycles while in_valid = 1.
  - Required: out_* stable, in_ready = 0, and the next instruction is accepted on the cycle out_ready rises.
- Flush:
  - Stimulus: assert flush with a valid bundle held and in_valid = 1.
  - Required: out_valid 0 next cycle, no intake during the flush cycle, normal intake the cycle after.
- Illegal:
  - Stimulus: instr 0x00000000, then opcode 1111111.
  - Required: out_illegal 1, out_imm 0, out_valid 1, no stall against a preceding lw x0..x31.
- Reset and saturation:
  - Assert reset asynchronously mid-transfer → out_valid and bubble_count 0 before the next edge.
  - With BUBBLE_CNT_W = 2, force 5 load-use pairs → bubble_count stays 3.
